// File: rtl/bus_port_pkg.sv
// ============================================================================
// Module      : bus_port_pkg
// Description : Shared state encoding and default timing constants for bus_port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_port_pkg;

  typedef enum logic [2:0] {
    ST_ISO    = 3'd0,
    ST_RX     = 3'd1,
    ST_TURN_T = 3'd2,
    ST_TX     = 3'd3,
    ST_TURN_R = 3'd4
  } state_e;

  localparam int TURN_DEFAULT = 1;
  localparam int TMO_DEFAULT  = 15;
  localparam int TMR_W        = 8;

endpackage

`default_nettype wire

// File: rtl/bus_port_timer.sv
// ============================================================================
// Module      : bus_port_timer
// Description : Loadable down-counter with a terminal (zero) flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_port_timer
  import bus_port_pkg::*;
(
  input  logic             clk,
  input  logic             rst_,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/bus_port.sv
// ============================================================================
// Module      : bus_port
// Description : Half-duplex bus port with transceiver direction control,
//               turnaround dead cycles and acknowledge timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_port
  import bus_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TURN  = TURN_DEFAULT,
  parameter int TMO   = TMO_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe_,
  output logic             tr_,
  output logic             rc_,
  input  logic             bus_stb_in,
  output logic             bus_ack_out,
  output logic             bus_stb_out,
  input  logic             bus_ack_in,
  output logic             err,
  input  logic             err_clr
);

  // Timer is loaded with N-1 so that a phase lasts exactly N cycles.
  localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURN - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(TMO - 1);

  state_e           state_q,    state_d;
  logic             tx_full_q,  tx_full_d;
  logic [WIDTH-1:0] tx_reg_q,   tx_reg_d;
  logic [WIDTH-1:0] rx_data_q,  rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             armed_q,    armed_d;
  logic             err_q,      err_d;

  logic             capture;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_done;

  bus_port_timer u_timer (
    .clk      (clk),
    .rst_     (rst_),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  always_comb begin
    capture    = (state_q == ST_RX) && bus_stb_in && armed_q && (!rx_valid_q || rx_ready);
    state_d    = state_q;
    tx_full_d  = tx_full_q;
    tx_reg_d   = tx_reg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    armed_d    = armed_q;
    err_d      = err_q;
    tmr_load   = 1'b0;
    tmr_val    = TURN_LOAD;
    tmr_en     = 1'b0;

    if (tx_valid && !tx_full_q) begin
      tx_full_d = 1'b1;
      tx_reg_d  = tx_data;
    end
    if (!bus_stb_in) begin
      armed_d = 1'b1;
    end
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (capture) begin
      rx_data_d  = bus_in;
      rx_valid_d = 1'b1;
      armed_d    = 1'b0;
    end
    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_ISO: state_d = ST_RX;
      ST_RX: begin
        if (!capture && tx_full_q && !bus_stb_in) begin
          state_d  = ST_TURN_T;
          tmr_load = 1'b1;
        end
      end
      ST_TURN_T: begin
        if (tmr_done) begin
          state_d  = ST_TX;
          tmr_load = 1'b1;
          tmr_val  = TMO_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_TX: begin
        if (bus_ack_in) begin
          tx_full_d = 1'b0;
          state_d   = ST_TURN_R;
          tmr_load  = 1'b1;
        end else if (tmr_done) begin
          // Timeout drops the word and overrides a concurrent err_clr.
          err_d     = 1'b1;
          tx_full_d = 1'b0;
          state_d   = ST_TURN_R;
          tmr_load  = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_TURN_R: begin
        if (tmr_done) begin
          state_d = ST_RX;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = ST_ISO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= ST_ISO;
      tx_full_q  <= 1'b0;
      tx_reg_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      armed_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_full_q  <= tx_full_d;
      tx_reg_q   <= tx_reg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      armed_q    <= armed_d;
      err_q      <= err_d;
    end
  end

  // Direction controls decode straight from the state register so reset releases the bus at once.
  assign tr_         = (state_q != ST_TX);
  assign rc_         = (state_q != ST_RX);
  assign bus_oe_     = (state_q != ST_TX);
  assign bus_out     = (state_q == ST_TX) ? tx_reg_q : '0;
  assign bus_stb_out = (state_q == ST_TX);
  assign bus_ack_out = capture;
  assign tx_ready    = !tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_port.sv
// ============================================================================
// Module      : tb_bus_port
// Description : Directed self-checking bench for bus_port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_port;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] bus_in = '0;
  logic [7:0] bus_out;
  logic       bus_oe_;
  logic       tr_;
  logic       rc_;
  logic       bus_stb_in = 1'b0;
  logic       bus_ack_out;
  logic       bus_stb_out;
  logic       bus_ack_in = 1'b0;
  logic       err;
  logic       err_clr = 1'b0;

  int tests = 0;
  int failures = 0;

  bus_port #(.WIDTH(8), .TURN(1), .TMO(15)) dut (
    .clk(clk), .rst_(rst_),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe_(bus_oe_),
    .tr_(tr_), .rc_(rc_),
    .bus_stb_in(bus_stb_in), .bus_ack_out(bus_ack_out),
    .bus_stb_out(bus_stb_out), .bus_ack_in(bus_ack_in),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Continuous safety checker on the transceiver controls.
  always @(negedge clk) begin
    tests++;
    if (!tr_ && !rc_) begin
      failures++;
      $display("FAIL safety_tr_rc got tr_=%b rc_=%b want never both 0", tr_, rc_);
    end
    tests++;
    if (!bus_oe_ && tr_) begin
      failures++;
      $display("FAIL safety_oe got bus_oe_=%b tr_=%b want no drive without tr_", bus_oe_, tr_);
    end
  end

  // Loads a word in RX and walks to the first TX cycle (TURN=1).
  task automatic go_tx(input logic [7:0] d);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    tests++; if (tr_ !== 1'b1 || rc_ !== 1'b1 || bus_oe_ !== 1'b1) begin failures++;
      $display("FAIL rst_dir got tr_=%b rc_=%b oe_=%b want 1 1 1", tr_, rc_, bus_oe_); end
    tests++; if (bus_out !== 8'h00 || rx_data !== 8'h00 || rx_valid !== 1'b0) begin failures++;
      $display("FAIL rst_data got bus_out=%h rx_data=%h rx_valid=%b want 00 00 0", bus_out, rx_data, rx_valid); end
    tests++; if (tx_ready !== 1'b1 || err !== 1'b0 || bus_stb_out !== 1'b0 || bus_ack_out !== 1'b0) begin failures++;
      $display("FAIL rst_flags got tx_ready=%b err=%b stb=%b ack=%b want 1 0 0 0", tx_ready, err, bus_stb_out, bus_ack_out); end
    @(negedge clk); rst_ = 1'b1; #1;
    tests++; if (tr_ !== 1'b1 || rc_ !== 1'b1) begin failures++;
      $display("FAIL iso_cycle got tr_=%b rc_=%b want 1 1", tr_, rc_); end
    @(negedge clk);
    tests++; if (rc_ !== 1'b0 || tr_ !== 1'b1 || bus_oe_ !== 1'b1 || tx_ready !== 1'b1) begin failures++;
      $display("FAIL rx_entry got rc_=%b tr_=%b oe_=%b tx_ready=%b want 0 1 1 1", rc_, tr_, bus_oe_, tx_ready); end
  endtask

  task automatic test_rx();
    int pulses = 0;
    bus_in = 8'hA5; bus_stb_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; if (bus_ack_out) pulses++;
      @(negedge clk);
    end
    tests++; if (pulses != 1) begin failures++;
      $display("FAIL rx_ack_pulses got %0d want 1", pulses); end
    tests++; if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin failures++;
      $display("FAIL rx_capture got rx_data=%h rx_valid=%b want a5 1", rx_data, rx_valid); end
    bus_stb_in = 1'b0;
    @(negedge clk);
    bus_in = 8'h5A; bus_stb_in = 1'b1; #1;
    tests++; if (bus_ack_out !== 1'b0) begin failures++;
      $display("FAIL rx_stall_ack got %b want 0", bus_ack_out); end
    @(negedge clk);
    tests++; if (rx_data !== 8'hA5) begin failures++;
      $display("FAIL rx_stall_data got %h want a5", rx_data); end
    rx_ready = 1'b1; #1;
    tests++; if (bus_ack_out !== 1'b1) begin failures++;
      $display("FAIL rx_drain_ack got %b want 1", bus_ack_out); end
    @(negedge clk);
    tests++; if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin failures++;
      $display("FAIL rx_second got rx_data=%h rx_valid=%b want 5a 1", rx_data, rx_valid); end
    bus_stb_in = 1'b0;
    @(negedge clk);
    tests++; if (rx_valid !== 1'b0) begin failures++;
      $display("FAIL rx_consume got rx_valid=%b want 0", rx_valid); end
    rx_ready = 1'b0;
  endtask

  task automatic test_tx();
    tx_data = 8'h3C; tx_valid = 1'b1; #1;
    tests++; if (tx_ready !== 1'b1) begin failures++;
      $display("FAIL tx_ready_idle got %b want 1", tx_ready); end
    @(negedge clk); tx_valid = 1'b0;
    tests++; if (tx_ready !== 1'b0 || rc_ !== 1'b0) begin failures++;
      $display("FAIL tx_loaded got tx_ready=%b rc_=%b want 0 0", tx_ready, rc_); end
    @(negedge clk);
    tests++; if (tr_ !== 1'b1 || rc_ !== 1'b1 || bus_oe_ !== 1'b1) begin failures++;
      $display("FAIL tx_turn_t got tr_=%b rc_=%b oe_=%b want 1 1 1", tr_, rc_, bus_oe_); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (tr_ !== 1'b0 || bus_oe_ !== 1'b0 || bus_out !== 8'h3C || bus_stb_out !== 1'b1) begin failures++;
        $display("FAIL tx_drive%0d got tr_=%b oe_=%b bus_out=%h stb=%b want 0 0 3c 1", i, tr_, bus_oe_, bus_out, bus_stb_out); end
    end
    bus_ack_in = 1'b1;
    @(negedge clk); bus_ack_in = 1'b0;
    tests++; if (tr_ !== 1'b1 || rc_ !== 1'b1 || bus_oe_ !== 1'b1 || bus_out !== 8'h00 || tx_ready !== 1'b1) begin failures++;
      $display("FAIL tx_turn_r got tr_=%b rc_=%b oe_=%b bus_out=%h tx_ready=%b want 1 1 1 00 1", tr_, rc_, bus_oe_, bus_out, tx_ready); end
    @(negedge clk);
    tests++; if (rc_ !== 1'b0 || tr_ !== 1'b1 || err !== 1'b0) begin failures++;
      $display("FAIL tx_back_rx got rc_=%b tr_=%b err=%b want 0 1 0", rc_, tr_, err); end
  endtask

  task automatic test_timeout();
    int n = 0;
    go_tx(8'h77);
    err_clr = 1'b1;
    while (!tr_ && n < 40) begin
      n++;
      @(negedge clk);
    end
    tests++; if (n != 15) begin failures++;
      $display("FAIL tmo_cycles got %0d want 15", n); end
    tests++; if (err !== 1'b1 || tx_ready !== 1'b1 || bus_oe_ !== 1'b1) begin failures++;
      $display("FAIL tmo_err got err=%b tx_ready=%b oe_=%b want 1 1 1", err, tx_ready, bus_oe_); end
    @(negedge clk); err_clr = 1'b0;
    tests++; if (err !== 1'b0 || rc_ !== 1'b0) begin failures++;
      $display("FAIL tmo_clear got err=%b rc_=%b want 0 0", err, rc_); end
  endtask

  task automatic test_priority();
    tx_data = 8'hC3; tx_valid = 1'b1;
    bus_in = 8'h11; bus_stb_in = 1'b1; rx_ready = 1'b1; #1;
    tests++; if (bus_ack_out !== 1'b1) begin failures++;
      $display("FAIL prio_ack got %b want 1", bus_ack_out); end
    @(negedge clk); tx_valid = 1'b0;
    tests++; if (rc_ !== 1'b0 || rx_data !== 8'h11 || tx_ready !== 1'b0) begin failures++;
      $display("FAIL prio_capture got rc_=%b rx_data=%h tx_ready=%b want 0 11 0", rc_, rx_data, tx_ready); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (rc_ !== 1'b0) begin failures++;
        $display("FAIL prio_hold%0d got rc_=%b want 0", i, rc_); end
    end
    bus_stb_in = 1'b0;
    @(negedge clk);
    tests++; if (rc_ !== 1'b1 || tr_ !== 1'b1) begin failures++;
      $display("FAIL prio_turn got rc_=%b tr_=%b want 1 1", rc_, tr_); end
    @(negedge clk);
    tests++; if (tr_ !== 1'b0 || bus_out !== 8'hC3) begin failures++;
      $display("FAIL prio_tx got tr_=%b bus_out=%h want 0 c3", tr_, bus_out); end
    bus_ack_in = 1'b1;
    @(negedge clk); bus_ack_in = 1'b0; rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_tx();
    go_tx(8'h99);
    tests++; if (tr_ !== 1'b0) begin failures++;
      $display("FAIL rmt_in_tx got tr_=%b want 0", tr_); end
    #2 rst_ = 1'b0; #1;
    tests++; if (tr_ !== 1'b1 || rc_ !== 1'b1 || bus_oe_ !== 1'b1 || bus_out !== 8'h00 || bus_stb_out !== 1'b0) begin failures++;
      $display("FAIL rmt_release got tr_=%b rc_=%b oe_=%b bus_out=%h stb=%b want 1 1 1 00 0", tr_, rc_, bus_oe_, bus_out, bus_stb_out); end
    tests++; if (tx_ready !== 1'b1) begin failures++;
      $display("FAIL rmt_tx_ready got %b want 1", tx_ready); end
    @(negedge clk); rst_ = 1'b1;
    @(negedge clk);
    tests++; if (rc_ !== 1'b0 || tx_ready !== 1'b1) begin failures++;
      $display("FAIL rmt_rx got rc_=%b tx_ready=%b want 0 1", rc_, tx_ready); end
    @(negedge clk);
    tests++; if (rc_ !== 1'b0 || tr_ !== 1'b1) begin failures++;
      $display("FAIL rmt_word_lost got rc_=%b tr_=%b want 0 1", rc_, tr_); end
  endtask

  initial begin
    test_reset();
    test_rx();
    test_tx();
    test_timeout();
    test_priority();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_port.md
BUS_PORT -- requirements
Module: bus_port

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width on both sides.
REQ-002 SHALL have parameter TURN, default 1, bus turnaround dead cycles (1..7).
REQ-003 SHALL have parameter TMO, default 15, acknowledge-timeout limit in TX cycles (1..255).
REQ-004 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port: rst_  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port: tx_data  in  WIDTH  local word to transmit.
REQ-007 SHALL have port: tx_valid  in  1  tx_data offered.
REQ-008 SHALL have port: tx_ready  out  1  tx holding register empty.
REQ-009 SHALL have port: rx_data  out  WIDTH  last captured bus word.
REQ-010 SHALL have port: rx_valid  out  1  rx register full.
REQ-011 SHALL have port: rx_ready  in  1  local consumer takes rx_data.
REQ-012 SHALL have port: bus_in  in  WIDTH  transceiver A-side value, sampled.
REQ-013 SHALL have port: bus_out  out  WIDTH  value driven onto A-side.
REQ-014 SHALL have port: bus_oe_  out  1  A-side driver enable, active-low.
REQ-015 SHALL have ports: tr_ and rc_  out  1 each  transceiver direction enables, active-low.
REQ-016 SHALL have ports: bus_stb_in  in  1  remote word valid; bus_ack_out  out  1  capture pulse.
REQ-017 SHALL have ports: bus_stb_out  out  1  local word valid; bus_ack_in  in  1  remote accepted.
REQ-018 SHALL have ports: err  out  1  sticky timeout flag; err_clr  in  1  clears err.

Function
REQ-019 SHALL implement states ISO, RX, TURN_T, TX, TURN_R.
REQ-020 SHALL force tr_=rc_=1 in ISO, TURN_T, TURN_R; rc_=0,tr_=1 in RX; tr_=0,rc_=1 in TX; tr_ and rc_ never both 0.
REQ-021 SHALL assert bus_oe_=0 only in TX; bus_out = tx holding register when bus_oe_=0, else 0.
REQ-022 ISO SHALL last exactly one cycle after reset release, then enter RX.
REQ-023 In RX, capture SHALL occur when bus_stb_in=1, armed=1 and rx register empty or being emptied that cycle: rx_data<=bus_in, rx_valid<=1, bus_ack_out=1 for one cycle, armed<=0.
REQ-024 armed SHALL set on any cycle bus_stb_in=0; one capture per strobe high period.
REQ-025 rx full with bus_stb_in=1 SHALL stall: no capture, no ack, bus_in ignored.
REQ-026 rx_valid SHALL clear on rx_valid & rx_ready unless a capture sets it the same cycle.
REQ-027 tx_ready = !tx_full; tx_valid & tx_ready SHALL load tx register and set tx_full, in any state.
REQ-028 RX SHALL go to TURN_T when tx_full=1, bus_stb_in=0 and no capture that cycle; capture has priority.
REQ-029 TURN_T and TURN_R SHALL each last exactly TURN cycles.
REQ-030 TX SHALL assert bus_stb_out=1 every TX cycle; on bus_ack_in=1: clear tx_full, go TURN_R.
REQ-031 TX timeout counter SHALL clear on TX entry; after TMO TX cycles without ack: err<=1, tx_full<=0 (word dropped), go TURN_R.
REQ-032 err_clr SHALL clear err; a timeout in the same cycle SHALL win (err stays 1).
REQ-033 bus_ack_out, bus_stb_out SHALL be 0 outside RX and TX respectively.

Reset
REQ-034 On rst_=0, immediately and regardless of clk: state ISO, tr_=rc_=1, bus_oe_=1, bus_out=0, rx_valid=0, rx_data=0, tx_full=0 (tx_ready=1), armed=0, err=0, counters 0, strobes/acks 0.
REQ-035 Reset mid-TX SHALL release the bus in the same instant; the pending word is lost.

Structure
REQ-036 Package bus_port_pkg SHALL hold state enum and default TURN/TMO constants.
REQ-037 One sub-module bus_port_timer (loadable down-counter with terminal flag) SHALL serve turnaround and timeout; all else in bus_port.

Verification
REQ-038 Reset release: cycle 1 tr_=rc_=1, cycle 2 rc_=0, tr_=1, bus_oe_=1, tx_ready=1.
REQ-039 RX: bus_in=8'hA5, stb high 3 cycles -> one ack pulse, rx_data=A5, rx_valid=1; second strobe while full -> no ack until rx_ready.
REQ-040 TX: tx_data=8'h3C, TURN=1, ack after 2 TX cycles -> 1 dead cycle, bus_out=3C with tr_=0 for 2 cycles, 1 dead cycle, back to RX.
REQ-041 Timeout: TMO=15, no ack -> 15 TX cycles, err=1, tx_ready=1, RX; err_clr -> err=0.
REQ-042 Simultaneous stb_in and tx_full in RX -> capture first, TX starts only after stb_in low.
REQ-043 Assert rst_ mid-TX -> tr_, bus_oe_ high before next clk edge; checker: never tr_=rc_=0, never bus_oe_=0 with tr_=1.
